// File: rtl/f_pc_fetch_pkg.sv
// Shared fetch/memory constants: address map, exception codes and next-PC source select.
package f_pc_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [1:0] ALIGN_WORD = 2'b11;
  localparam logic [1:0] ALIGN_HALF = 2'b01;
  localparam logic [1:0] ALIGN_BYTE = 2'b00;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_REDIR,
    NPC_PEND,
    NPC_EPC,
    NPC_EXC
  } npc_sel_e;

endpackage

// File: rtl/f_addr_check.sv
// Combinational address-error check: misaligned (per align mask) or outside [LO_ADDR, HI_ADDR].
// Shared by the fetch PC and the M-stage load address; zero latency, no flow control.
module f_addr_check #(
  parameter logic [31:0] LO_ADDR = 32'h0000_3000,
  parameter logic [31:0] HI_ADDR = 32'h0000_6FFC
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  align_mask_i,
  output logic        adel_o
);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = |(addr_i[1:0] & align_mask_i);
  assign out_of_range = (addr_i < LO_ADDR) || (addr_i > HI_ADDR);
  assign adel_o       = misaligned | out_of_range;

endmodule

// File: rtl/f_pc_fetch.sv
// Fetch-stage PC generator with pending-redirect latch and AdEL fetch check.
// PC updates at posedge; outputs are combinational on pc (latency 0); en=0 stalls but req/eret still redirect.
module f_pc_fetch
  import f_pc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        d_is_jump,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic [4:0]  F_exc_code,
  output logic        F_is_BD
);

  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  npc_sel_e    npc_sel;
  logic        fetch_adel;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (req)               npc_sel = NPC_EXC;
    else if (eret_req)     npc_sel = NPC_EPC;
    else if (!en)          npc_sel = NPC_HOLD;
    else if (redir_valid)  npc_sel = NPC_REDIR;
    else if (pend_v_q)     npc_sel = NPC_PEND;
  end

  always_comb begin
    pc_d       = pc_q + 32'd4;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    unique case (npc_sel)
      NPC_EXC: begin
        pc_d     = EXC_PC;
        pend_v_d = 1'b0;
      end
      NPC_EPC: begin
        pc_d     = epc;
        pend_v_d = 1'b0;
      end
      NPC_HOLD: begin
        pc_d = pc_q;
        // A redirect resolved while stalled is remembered; the newest one wins.
        if (redir_valid) begin
          pend_v_d   = 1'b1;
          pend_tgt_d = redir_target;
        end
      end
      NPC_REDIR: begin
        pc_d     = redir_target;
        pend_v_d = 1'b0;
      end
      NPC_PEND: begin
        pc_d     = pend_tgt_q;
        pend_v_d = 1'b0;
      end
      default: begin
        pc_d = pc_q + 32'd4;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  f_addr_check #(
    .LO_ADDR(IM_BASE),
    .HI_ADDR(IM_TOP)
  ) u_addr_check (
    .addr_i      (pc_q),
    .align_mask_i(ALIGN_WORD),
    .adel_o      (fetch_adel)
  );

  assign im_addr    = pc_q;
  assign F_PC       = pc_q;
  assign F_exc_code = fetch_adel ? EXC_ADEL : EXC_INT;
  assign F_Instr    = fetch_adel ? 32'h0 : im_rdata;
  assign F_is_BD    = d_is_jump & ~req;

endmodule

// File: tb/tb_f_pc_fetch.sv
// Bench for f_pc_fetch: directed scenarios plus randomized run against a priority-rule PC model.
module tb_f_pc_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic        d_is_jump = 1'b0;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic [4:0]  F_exc_code;
  logic        F_is_BD;

  int n_chk = 0;
  int n_pass = 0;

  // Model state
  logic [31:0] m_pc = 32'h0;
  bit          m_pv = 0;
  logic [31:0] m_pt = 32'h0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: word content is a simple function of address.
  assign im_rdata = ~im_addr;

  f_pc_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .eret_req    (eret_req),
    .epc         (epc),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
    .d_is_jump   (d_is_jump),
    .im_rdata    (im_rdata),
    .im_addr     (im_addr),
    .F_PC        (F_PC),
    .F_Instr     (F_Instr),
    .F_exc_code  (F_exc_code),
    .F_is_BD     (F_is_BD)
  );

  function automatic bit model_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  // Advance one clock; model applies the documented priority list to the current inputs.
  task automatic tick();
    logic [31:0] npc;
    bit          npv;
    logic [31:0] npt;
    npc = m_pc + 32'd4;
    npv = m_pv;
    npt = m_pt;
    if (reset) begin
      npc = 32'h3000; npv = 0; npt = 32'h0;
    end else if (req) begin
      npc = 32'h4180; npv = 0;
    end else if (eret_req) begin
      npc = epc; npv = 0;
    end else if (!en) begin
      npc = m_pc;
      if (redir_valid) begin npv = 1; npt = redir_target; end
    end else if (redir_valid) begin
      npc = redir_target; npv = 0;
    end else if (m_pv) begin
      npc = m_pt; npv = 0;
    end
    @(posedge clk);
    #1;
    m_pc = npc;
    m_pv = npv;
    m_pt = npt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_chk++; if (F_PC !== 32'h3000) $display("FAIL reset_pc got %h exp %h", F_PC, 32'h3000); else n_pass++;
    n_chk++; if (F_exc_code !== 5'd0) $display("FAIL reset_exc got %0d exp 0", F_exc_code); else n_pass++;
    n_chk++; if (F_is_BD !== 1'b0) $display("FAIL reset_bd got %b exp 0", F_is_BD); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h3000 + 32'(4 * i);
      n_chk++; if (F_PC !== exp_pc) $display("FAIL seq_pc[%0d] got %h exp %h", i, F_PC, exp_pc); else n_pass++;
      n_chk++; if (F_exc_code !== 5'd0) $display("FAIL seq_exc[%0d] got %0d exp 0", i, F_exc_code); else n_pass++;
      n_chk++; if (F_Instr !== ~exp_pc) $display("FAIL seq_instr[%0d] got %h exp %h", i, F_Instr, ~exp_pc); else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    en = 1'b1; redir_valid = 1'b1; redir_target = 32'h3100; d_is_jump = 1'b1;
    #1;
    n_chk++; if (F_is_BD !== 1'b1) $display("FAIL redir_bd got %b exp 1", F_is_BD); else n_pass++;
    tick();
    redir_valid = 1'b0; d_is_jump = 1'b0;
    #1;
    n_chk++; if (F_PC !== 32'h3100) $display("FAIL redir_pc got %h exp %h", F_PC, 32'h3100); else n_pass++;
  endtask

  task automatic test_stall_pending();
    en = 1'b0; redir_valid = 1'b1; redir_target = 32'h3200;
    tick();
    redir_valid = 1'b0;
    tick();
    n_chk++; if (F_PC !== 32'h3100) $display("FAIL stall_hold got %h exp %h", F_PC, 32'h3100); else n_pass++;
    en = 1'b1;
    tick();
    n_chk++; if (F_PC !== 32'h3200) $display("FAIL pend_apply got %h exp %h", F_PC, 32'h3200); else n_pass++;
    en = 1'b0; redir_valid = 1'b1; redir_target = 32'h3250;
    tick();
    en = 1'b1; redir_target = 32'h3300;
    tick();
    n_chk++; if (F_PC !== 32'h3300) $display("FAIL live_over_pend got %h exp %h", F_PC, 32'h3300); else n_pass++;
    redir_valid = 1'b0;
    tick();
    n_chk++; if (F_PC !== 32'h3304) $display("FAIL pend_cleared got %h exp %h", F_PC, 32'h3304); else n_pass++;
  endtask

  task automatic test_req();
    en = 1'b1; redir_valid = 1'b1; redir_target = 32'h3010;
    tick();
    en = 1'b0; redir_target = 32'h3400;
    tick();
    redir_valid = 1'b0; req = 1'b1; d_is_jump = 1'b1;
    #1;
    n_chk++; if (F_is_BD !== 1'b0) $display("FAIL req_bd got %b exp 0", F_is_BD); else n_pass++;
    tick();
    n_chk++; if (F_PC !== 32'h4180) $display("FAIL req_stalled got %h exp %h", F_PC, 32'h4180); else n_pass++;
    req = 1'b0; d_is_jump = 1'b0; en = 1'b1;
    tick();
    n_chk++; if (F_PC !== 32'h4184) $display("FAIL req_pend_clr got %h exp %h", F_PC, 32'h4184); else n_pass++;
    req = 1'b1; eret_req = 1'b1; epc = 32'h3500;
    tick();
    n_chk++; if (F_PC !== 32'h4180) $display("FAIL req_over_eret got %h exp %h", F_PC, 32'h4180); else n_pass++;
    req = 1'b0; eret_req = 1'b0;
  endtask

  task automatic test_eret_adel();
    eret_req = 1'b1; epc = 32'h3021;
    tick();
    n_chk++; if (F_PC !== 32'h3021) $display("FAIL eret_pc got %h exp %h", F_PC, 32'h3021); else n_pass++;
    n_chk++; if (F_exc_code !== 5'd4) $display("FAIL adel_misalign got %0d exp 4", F_exc_code); else n_pass++;
    n_chk++; if (F_Instr !== 32'h0) $display("FAIL adel_nop got %h exp 0", F_Instr); else n_pass++;
    epc = 32'h7000;
    tick();
    n_chk++; if (F_exc_code !== 5'd4) $display("FAIL adel_above_top got %0d exp 4", F_exc_code); else n_pass++;
    epc = 32'h6FFC;
    tick();
    n_chk++; if (F_exc_code !== 5'd0) $display("FAIL top_legal got %0d exp 0", F_exc_code); else n_pass++;
    n_chk++; if (F_Instr !== ~32'h6FFC) $display("FAIL top_instr got %h exp %h", F_Instr, ~32'h6FFC); else n_pass++;
    en = 1'b0; epc = 32'h3000;
    tick();
    n_chk++; if (F_PC !== 32'h3000) $display("FAIL eret_stalled got %h exp %h", F_PC, 32'h3000); else n_pass++;
    eret_req = 1'b0; en = 1'b1;
  endtask

  task automatic test_wrap();
    en = 1'b1; redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    #1;
    n_chk++; if (F_exc_code !== 5'd4) $display("FAIL wrap_top_adel got %0d exp 4", F_exc_code); else n_pass++;
    tick();
    n_chk++; if (F_PC !== 32'h0) $display("FAIL wrap_pc got %h exp 0", F_PC); else n_pass++;
    n_chk++; if (F_exc_code !== 5'd4) $display("FAIL wrap_adel got %0d exp 4", F_exc_code); else n_pass++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(32'h2FF0, 32'h7010));
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_random();
    logic [31:0] e_instr;
    logic [4:0]  e_exc;
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      req          = ($urandom_range(0, 15) == 0);
      eret_req     = ($urandom_range(0, 15) == 0);
      en           = ($urandom_range(0, 3) != 0);
      redir_valid  = ($urandom_range(0, 3) == 0);
      redir_target = rand_addr();
      epc          = rand_addr();
      d_is_jump    = 1'($urandom_range(0, 1));
      #1;
      e_exc   = model_adel(m_pc) ? 5'd4 : 5'd0;
      e_instr = model_adel(m_pc) ? 32'h0 : ~m_pc;
      n_chk++; if (F_PC !== m_pc) $display("FAIL rnd_pc[%0d] got %h exp %h", i, F_PC, m_pc); else n_pass++;
      n_chk++; if (im_addr !== m_pc) $display("FAIL rnd_imaddr[%0d] got %h exp %h", i, im_addr, m_pc); else n_pass++;
      n_chk++; if (F_exc_code !== e_exc) $display("FAIL rnd_exc[%0d] got %0d exp %0d", i, F_exc_code, e_exc); else n_pass++;
      n_chk++; if (F_Instr !== e_instr) $display("FAIL rnd_instr[%0d] got %h exp %h", i, F_Instr, e_instr); else n_pass++;
      n_chk++; if (F_is_BD !== (d_is_jump && !req)) $display("FAIL rnd_bd[%0d] got %b exp %b", i, F_is_BD, d_is_jump && !req); else n_pass++;
      tick();
    end
    reset = 1'b0; req = 1'b0; eret_req = 1'b0; redir_valid = 1'b0; d_is_jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_pending();
    test_req();
    test_eret_adel();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
